// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encodings,
// receiver FSM states and the bit-period helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int clks_per_bit(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter. tick is high during the last cycle of a
// period; on that edge the counter reloads a full bit period, so ticks recur
// every CLKS_PER_BIT cycles after the first (load_value cycles after load).
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WIDTH        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tick
);

  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(CLKS_PER_BIT);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(1);

  logic [WIDTH-1:0] count;

  assign tick = (count == LAST) && !load;

  // Counter: load wins, reload on terminal count, park at zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count == LAST) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_router.sv
// UART receiver feeding CHANNELS byte sinks. The destination is captured when
// the start bit is confirmed; a good frame strobes exactly one data_valid bit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on rxs
// START    | half-bit wait, then confirm start bit is still low
// DATA     | sample DATA_BITS data bits at mid-bit, LSB first
// PARITY   | sample the parity bit
// STOP     | sample stop bit, emit valid / framing / parity strobe
// BREAK    | stop bit was low; wait for the line to return high
module uart_rx_router
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ = 25_175_000,
  parameter int BAUD_RATE        = 9600,
  parameter int CHANNELS         = 2,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             rx,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] channel_select,
  output logic [DATA_BITS-1:0]                             data,
  output logic [CHANNELS-1:0]                              data_valid,
  output logic                                             framing_error,
  output logic                                             parity_error,
  output logic                                             busy
);

  localparam int CPB   = clks_per_bit(CLK_FREQUENCY_HZ, BAUD_RATE);
  localparam int TW    = $clog2(CPB + 1);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BW    = $clog2(DATA_BITS + 1);

  rx_state_t            state, state_next;
  logic                 rx_meta, rxs, rxs_d;
  logic                 timer_load, tick;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_next;
  logic [SEL_W-1:0]     sel_q, sel_next;
  logic                 par_q, par_next;
  logic                 parity_ok;
  logic [DATA_BITS-1:0] data_next;
  logic [CHANNELS-1:0]  valid_next;
  logic                 fe_next, pe_next, busy_next;

  uart_bit_timer #(
    .CLKS_PER_BIT(CPB),
    .WIDTH       (TW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load),
    .load_value(TW'(CPB / 2)),
    .tick      (tick)
  );

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // Parity check over the received word and the stored parity bit.
  always_comb begin
    parity_ok = 1'b1;
    if (PARITY == PARITY_EVEN) begin
      parity_ok = ((^shift_q) ^ par_q) == 1'b0;
    end else if (PARITY == PARITY_ODD) begin
      parity_ok = ((^shift_q) ^ par_q) == 1'b1;
    end
  end

  // FSM state, datapath registers and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      sel_q         <= '0;
      par_q         <= 1'b0;
      data          <= '0;
      data_valid    <= '0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      shift_q       <= shift_next;
      bit_cnt_q     <= bit_cnt_next;
      sel_q         <= sel_next;
      par_q         <= par_next;
      data          <= data_next;
      data_valid    <= valid_next;
      framing_error <= fe_next;
      parity_error  <= pe_next;
      busy          <= busy_next;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    bit_cnt_next = bit_cnt_q;
    sel_next     = sel_q;
    par_next     = par_q;
    data_next    = data;
    valid_next   = '0;
    fe_next      = 1'b0;
    pe_next      = 1'b0;
    timer_load   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!rxs && rxs_d) begin
          state_next = ST_START;
          timer_load = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rxs) begin
            state_next   = ST_DATA;
            sel_next     = channel_select;
            bit_cnt_next = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next = {rxs, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          par_next   = rxs;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (!rxs) begin
            fe_next    = 1'b1;
            state_next = ST_BREAK;
          end else if (!parity_ok) begin
            pe_next    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_IDLE;
            // Out-of-range destinations drop the frame without a strobe.
            if (int'(sel_q) < CHANNELS) begin
              data_next = shift_q;
              for (int i = 0; i < CHANNELS; i++) begin
                valid_next[i] = (int'(sel_q) == i);
              end
            end
          end
        end
      end
      ST_BREAK: begin
        if (rxs) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = !((state_next == ST_IDLE) || (state_next == ST_START));
  end

endmodule
